isp_frame_ctrl: RTL and testbench
=================================

Name: isp_frame_ctrl

Overview:
- Frame-level sequencer for the ISP pipeline (demosaic -> denoise -> mean -> gamma).
- Gates the input pixel stream into the pipeline.
- Latches `mode` into per-stage enable bits at frame boundaries only, so a stage's configuration never changes mid-frame.
- Tracks frames in flight between pipeline input and pipeline output, drains the pipeline before applying a new mode, and runs a stall watchdog.

Parameters:
- MAX_INFLIGHT, 2, max frames accepted at input but not yet completed at output (1..3).
- TIMEOUT_W, 20, width of watchdog counter; timeout fires at 2^TIMEOUT_W-1 idle cycles.
- CNT_W, 16, width of completed-frame counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  4  requested config; bit0 demosaic, bit1 denoise, bit2 mean, bit3 gamma enable
- valid_in  in  1  pixel valid from the source, before gating
- last_pic_in  in  1  last pixel of frame, qualified by valid_in
- in_ready  out  1  controller accepts input; a pixel enters the pipeline only when valid_in&in_ready
- pipe_valid  out  1  valid_in&in_ready, the valid driven into the first stage
- cfg_en  out  4  latched stage enables (same bit order as mode)
- valid_out  in  1  valid observed at pipeline output (gamma)
- last_pic_out  in  1  last pixel of frame at output, qualified by valid_out
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse per completed output frame
- frame_cnt  out  CNT_W  completed-frame count, wraps
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - in_ready=1; cfg_en=4'b0000; busy=0; frame_done=0; frame_cnt=0; err_timeout=0.
  - state=IDLE; inflight=0; in_frame=0; wdog=0.
- Definitions:
  - accept = valid_in&in_ready.
  - eof_in = accept&last_pic_in.
  - eof_out = valid_out&last_pic_out.
- pipe_valid is purely combinational from valid_in and in_ready; zero latency.
- in_frame is set on accept, cleared on eof_in. A single-pixel frame (first pixel also last) leaves in_frame=0.
- IDLE:
  - in_ready=1.
  - On accept: cfg_en<=mode in the same edge; go to RUN.
  - The first pixel is passed through in this cycle; the stage registers it with the new cfg_en on the following edge.
- RUN:
  - in_ready = in_frame | (inflight<MAX_INFLIGHT & mode==cfg_en).
  - An in-progress frame is never stalled by the controller.
  - On eof_in: if mode!=cfg_en, go to DRAIN; otherwise stay in RUN.
  - Between frames, if mode!=cfg_en (in_frame=0), go to DRAIN.
  - A mode change mid-frame is ignored until eof_in.
- DRAIN:
  - in_ready=0.
  - When inflight==0 (including the decrement this cycle): go to IDLE. The new mode is latched at the next accept.
- inflight counter:
  - +1 on eof_in, -1 on eof_out.
  - Both in the same cycle: unchanged.
  - eof_out with inflight==0 is ignored; saturates at 0.
  - Never exceeds MAX_INFLIGHT; in_ready gating guarantees this.
- frame_done = registered eof_out when inflight>0; 1-cycle latency. frame_cnt increments on the same edge, wrapping at 2^CNT_W.
- Watchdog:
  - wdog clears on valid_out or when inflight==0.
  - Otherwise wdog increments each cycle.
  - At all-ones: err_timeout<=1 (sticky until reset); inflight<=0; in_frame<=0; state<=IDLE; wdog<=0.
- Boundaries:
  - Reset mid-frame returns all state to reset values immediately; cfg_en=0 bypasses all stages.
  - Back-to-back frames with unchanged mode have zero bubble.
  - eof_in and a watchdog expiry in the same cycle: watchdog wins.

Decomposition:
- Shared package:
  - STATE_IDLE/RUN/DRAIN encoding (2 bits).
  - MODE_DEMOSAIC=0, MODE_DENOISE=1, MODE_MEAN=2, MODE_GAMMA=3 bit indices.
  - Reuse the existing COLOR_DEPTH define elsewhere; not needed here.
- One natural sub-module: isp_stall_wdog (counter, clear/expire logic), instantiated once.

Test Plan:
- Single frame: mode=4'hF, 16-pixel frame, 1-cycle-valid output 20 cycles later.
  - cfg_en=F after first accept.
  - in_ready=1 throughout.
  - frame_done pulses 1 cycle after output eof.
  - frame_cnt=1; busy remains 1 (RUN).
- Mode change mid-frame:
  - Mode changes from F to 5 at pixel 8 of 16.
  - cfg_en stays F until frame end; state goes to DRAIN.
  - in_ready=0 until output eof.
  - State goes to IDLE; the next frame's first accept latches cfg_en=5.
- Inflight limit:
  - MAX_INFLIGHT=2, three back-to-back 4-pixel frames, output held idle.
  - in_ready drops after the 2nd eof_in.
  - in_ready rises the cycle eof_out drops inflight to 1.
- Simultaneous eof_in and eof_out with inflight=1: inflight stays 1; frame_done pulses; no stall.
- Watchdog:
  - TIMEOUT_W=4, one frame in, valid_out never asserted.
  - After 15 idle cycles: err_timeout=1, state goes to IDLE, inflight=0.
  - err_timeout holds until rst_n pulse.
- Async reset mid-DRAIN: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/isp_frame_ctrl_pkg.sv
// Shared encodings for the ISP frame sequencer: FSM states, stage-enable bit indices
// and the in-flight counter width.
package isp_frame_ctrl_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_RUN   = 2'd1;
    localparam logic [1:0] STATE_DRAIN = 2'd2;

    localparam int unsigned MODE_DEMOSAIC = 0;
    localparam int unsigned MODE_DENOISE  = 1;
    localparam int unsigned MODE_MEAN     = 2;
    localparam int unsigned MODE_GAMMA    = 3;
    localparam int unsigned NUM_STAGES    = MODE_GAMMA + 1;

    typedef logic [NUM_STAGES-1:0] mode_t;

    // Wide enough for MAX_INFLIGHT up to 3.
    localparam int unsigned INFL_W = 2;

endpackage

// File: rtl/isp_frame_ctrl_if.sv
// Pixel-side and pipeline-side handshake plus status signals of the frame sequencer.
interface isp_frame_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();
    import isp_frame_ctrl_pkg::*;

    mode_t            mode;
    logic             valid_in;
    logic             last_pic_in;
    logic             in_ready;
    logic             pipe_valid;
    mode_t            cfg_en;
    logic             valid_out;
    logic             last_pic_out;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] frame_cnt;
    logic             err_timeout;

    modport slave (
        input  mode, valid_in, last_pic_in, valid_out, last_pic_out,
        output in_ready, pipe_valid, cfg_en, busy, frame_done, frame_cnt, err_timeout
    );

    modport master (
        output mode, valid_in, last_pic_in, valid_out, last_pic_out,
        input  in_ready, pipe_valid, cfg_en, busy, frame_done, frame_cnt, err_timeout
    );

endinterface

// File: rtl/isp_stall_wdog.sv
// Stall watchdog: counts cycles without progress and pulses expire_o when the count
// reaches all-ones, then restarts from zero.
module isp_stall_wdog #(
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] CntOne = TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    assign expire_o = ~clr_i & (&cnt_q);

    always_comb begin
        cnt_d = cnt_q + CntOne;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/isp_frame_ctrl.sv
// Frame-level sequencer for the ISP pipeline: gates input pixels, latches stage enables
// only at frame boundaries, tracks frames in flight and drains before a mode change.
module isp_frame_ctrl
    import isp_frame_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned TIMEOUT_W    = 20,
    parameter int unsigned CNT_W        = 16
) (
    input logic             clk,
    input logic             rst_n,
    isp_frame_ctrl_if.slave ctrl_io
);

    localparam logic [INFL_W-1:0] MaxInfl = INFL_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic              in_frame_q, in_frame_d;
    mode_t             cfg_en_q, cfg_en_d;
    logic              frame_done_q;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              err_q;

    logic in_ready;
    logic accept;
    logic eof_in;
    logic eof_out;
    logic out_done;
    logic mode_diff;
    logic wdog_clr;
    logic wdog_expire;

    assign mode_diff = ctrl_io.mode != cfg_en_q;
    assign accept    = ctrl_io.valid_in & in_ready;
    assign eof_in    = accept & ctrl_io.last_pic_in;
    assign eof_out   = ctrl_io.valid_out & ctrl_io.last_pic_out;
    // An output frame end only counts when a frame is actually outstanding.
    assign out_done  = eof_out & (inflight_q != '0);

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            STATE_IDLE:  in_ready = 1'b1;
            STATE_RUN:   in_ready = in_frame_q | ((inflight_q < MaxInfl) & ~mode_diff);
            STATE_DRAIN: in_ready = 1'b0;
            default:     in_ready = 1'b0;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (eof_in && !out_done) begin
            inflight_d = inflight_q + 2'd1;
        end else if (!eof_in && out_done) begin
            inflight_d = inflight_q - 2'd1;
        end

        in_frame_d = in_frame_q;
        if (eof_in) begin
            in_frame_d = 1'b0;
        end else if (accept) begin
            in_frame_d = 1'b1;
        end

        state_d  = state_q;
        cfg_en_d = cfg_en_q;
        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    cfg_en_d = ctrl_io.mode;
                    state_d  = STATE_RUN;
                end
            end
            STATE_RUN: begin
                // Mid-frame mode changes wait for the frame's last pixel.
                if ((eof_in || !in_frame_q) && mode_diff) begin
                    state_d = STATE_DRAIN;
                end
            end
            STATE_DRAIN: begin
                if (inflight_d == '0) begin
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase

        if (wdog_expire) begin
            inflight_d = '0;
            in_frame_d = 1'b0;
            state_d    = STATE_IDLE;
        end
    end

    assign frame_cnt_d = out_done ? frame_cnt_q + CntOne : frame_cnt_q;
    assign wdog_clr    = ctrl_io.valid_out | (inflight_q == '0);

    isp_stall_wdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wdog_clr),
        .expire_o (wdog_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_IDLE;
            inflight_q   <= '0;
            in_frame_q   <= 1'b0;
            cfg_en_q     <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            in_frame_q   <= in_frame_d;
            cfg_en_q     <= cfg_en_d;
            frame_done_q <= out_done;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_q | wdog_expire;
        end
    end

    assign ctrl_io.in_ready    = in_ready;
    assign ctrl_io.pipe_valid  = accept;
    assign ctrl_io.cfg_en      = cfg_en_q;
    assign ctrl_io.busy        = state_q != STATE_IDLE;
    assign ctrl_io.frame_done  = frame_done_q;
    assign ctrl_io.frame_cnt   = frame_cnt_q;
    assign ctrl_io.err_timeout = err_q;

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Bench for isp_frame_ctrl: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a frame-queue reference model.
module tb_isp_frame_ctrl;

    localparam int unsigned MaxInfl  = 2;
    localparam int unsigned TimeoutW = 5;
    localparam int unsigned CntW     = 4;
    localparam int          WdogMax  = (1 << TimeoutW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    isp_frame_ctrl_if #(.CNT_W(CntW)) bus ();

    isp_frame_ctrl #(
        .MAX_INFLIGHT (MaxInfl),
        .TIMEOUT_W    (TimeoutW),
        .CNT_W        (CntW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_io (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frames in flight as a queue of frame ids.
    bit         m_run, m_drain, m_mid, m_done, m_err;
    logic [3:0] m_cfg;
    int         m_cnt, m_stall, m_fid;
    int         m_q[$];

    always @(negedge clk) begin : model
        bit exp_rdy, acc, ein, eout, had, stalled, expire;
        if (!rst_n) begin
            m_run = 0; m_drain = 0; m_mid = 0; m_done = 0; m_err = 0;
            m_cfg = 4'h0; m_cnt = 0; m_stall = 0;
            m_q.delete();
        end
        if (!m_run)       exp_rdy = 1'b1;
        else if (m_drain) exp_rdy = 1'b0;
        else exp_rdy = m_mid || (m_q.size() < MaxInfl && bus.mode == m_cfg);

        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("pipe_valid", 32'(bus.pipe_valid), 32'(bus.valid_in & exp_rdy));
        chk("cfg_en", 32'(bus.cfg_en), 32'(m_cfg));
        chk("busy", 32'(bus.busy), 32'(m_run));
        chk("frame_done", 32'(bus.frame_done), 32'(m_done));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
        chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));

        if (rst_n) begin
            acc     = bus.valid_in && exp_rdy;
            ein     = acc && bus.last_pic_in;
            eout    = bus.valid_out && bus.last_pic_out;
            had     = m_q.size() > 0;
            stalled = had && !bus.valid_out;
            expire  = stalled && m_stall == WdogMax;
            m_done  = eout && had;
            if (m_done) m_cnt = (m_cnt + 1) % (1 << CntW);
            if (m_done) void'(m_q.pop_front());
            if (ein) begin
                m_q.push_back(m_fid);
                m_fid++;
            end
            if (!m_run) begin
                if (acc) begin
                    m_cfg = bus.mode;
                    m_run = 1;
                end
            end else if (!m_drain) begin
                if ((ein || !m_mid) && bus.mode != m_cfg) m_drain = 1;
            end else if (m_q.size() == 0) begin
                m_run = 0;
                m_drain = 0;
            end
            m_mid   = ein ? 1'b0 : (acc ? 1'b1 : m_mid);
            m_stall = (stalled && !expire) ? m_stall + 1 : 0;
            if (expire) begin
                m_err = 1; m_mid = 0; m_run = 0; m_drain = 0;
                m_q.delete();
            end
        end
    end

    task automatic out_eof();
        bus.valid_out = 1'b1;
        bus.last_pic_out = 1'b1;
        tick();
        bus.valid_out = 1'b0;
        bus.last_pic_out = 1'b0;
    endtask

    logic [3:0] modes[4] = '{4'hF, 4'h5, 4'h0, 4'hA};

    initial begin
        int n;
        bit quiet;
        bus.mode = 4'h0; bus.valid_in = 0; bus.last_pic_in = 0;
        bus.valid_out = 0; bus.last_pic_out = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_cfg_en", 32'(bus.cfg_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single 16-pixel frame, mode F.
        bus.mode = 4'hF;
        for (int i = 0; i < 16; i++) begin
            bus.valid_in = 1'b1;
            bus.last_pic_in = (i == 15);
            @(negedge clk);
            chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
            if (i == 1) chk("t1_cfg_en", 32'(bus.cfg_en), 32'hF);
            tick();
        end
        bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
        repeat (20) tick();
        out_eof();
        @(negedge clk);
        chk("t1_frame_done", 32'(bus.frame_done), 32'd1);
        chk("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        tick();

        // Mode change mid-frame.
        for (int i = 0; i < 16; i++) begin
            if (i == 8) bus.mode = 4'h5;
            bus.valid_in = 1'b1;
            bus.last_pic_in = (i == 15);
            tick();
        end
        bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
        @(negedge clk);
        chk("t2_cfg_hold", 32'(bus.cfg_en), 32'hF);
        chk("t2_drain_ready", 32'(bus.in_ready), 32'd0);
        tick();
        repeat (4) tick();
        out_eof();
        @(negedge clk);
        chk("t2_idle_busy", 32'(bus.busy), 32'd0);
        chk("t2_idle_ready", 32'(bus.in_ready), 32'd1);
        chk("t2_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        tick();
        bus.valid_in = 1'b1; bus.last_pic_in = 1'b1;
        tick();
        bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
        @(negedge clk);
        chk("t2_new_cfg", 32'(bus.cfg_en), 32'h5);
        tick();

        // In-flight limit: two frames accepted, the third stalls until an output frame ends.
        out_eof();
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 4; p++) begin
                bus.valid_in = 1'b1;
                bus.last_pic_in = (p == 3);
                tick();
            end
        end
        bus.last_pic_in = 1'b0;
        @(negedge clk);
        chk("t3_limit_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_limit_pv", 32'(bus.pipe_valid), 32'd0);
        tick();
        tick();
        out_eof();
        @(negedge clk);
        chk("t3_reopen_ready", 32'(bus.in_ready), 32'd1);
        tick();
        for (int p = 1; p < 4; p++) begin
            bus.last_pic_in = (p == 3);
            tick();
        end
        bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
        out_eof();
        out_eof();

        // Simultaneous eof_in and eof_out with one frame in flight.
        for (int p = 0; p < 8; p++) begin
            bus.valid_in = 1'b1;
            bus.last_pic_in = (p == 3 || p == 7);
            if (p == 7) begin
                bus.valid_out = 1'b1;
                bus.last_pic_out = 1'b1;
            end
            tick();
        end
        bus.valid_in = 0; bus.last_pic_in = 0; bus.valid_out = 0; bus.last_pic_out = 0;
        @(negedge clk);
        chk("t4_done", 32'(bus.frame_done), 32'd1);
        chk("t4_ready", 32'(bus.in_ready), 32'd1);
        tick();
        out_eof();
        @(negedge clk);
        chk("t4_frame_cnt", 32'(bus.frame_cnt), 32'd8);
        tick();
        out_eof();
        @(negedge clk);
        chk("t4_spurious_done", 32'(bus.frame_done), 32'd0);
        tick();

        // Watchdog: one frame in, output never responds.
        bus.valid_in = 1'b1; bus.last_pic_in = 1'b1;
        tick();
        bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
        n = 0;
        while (!bus.err_timeout && n < 60) begin
            tick();
            n++;
        end
        chk("t5_wdog_latency", 32'(n), 32'd32);
        @(negedge clk);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        tick();
        repeat (10) tick();
        chk("t5_err_sticky", 32'(bus.err_timeout), 32'd1);

        rst_n = 1'b0;
        #1;
        chk("rst_err_clear", 32'(bus.err_timeout), 32'd0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic with periodic output-quiet windows to provoke timeouts.
        for (int c = 0; c < 4000; c++) begin
            quiet = (c % 1000) >= 940;
            bus.valid_in = ($urandom % 4) != 0;
            bus.last_pic_in = ($urandom % 6) == 0;
            if ($urandom % 50 == 0) bus.mode = modes[$urandom % 4];
            bus.valid_out = !quiet && ($urandom % 3 == 0);
            bus.last_pic_out = ($urandom % 2) == 0;
            tick();
        end
        bus.valid_in = 0; bus.last_pic_in = 0; bus.valid_out = 0; bus.last_pic_out = 0;

        // Asynchronous reset while draining.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.mode = 4'hF;
        tick();
        bus.valid_in = 1'b1; bus.last_pic_in = 1'b1;
        tick();
        bus.valid_in = 1'b0; bus.last_pic_in = 1'b0;
        bus.mode = 4'h5;
        tick();
        tick();
        @(negedge clk);
        chk("t6_drain_busy", 32'(bus.busy), 32'd1);
        chk("t6_drain_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_async_cfg", 32'(bus.cfg_en), 32'd0);
        chk("t6_async_busy", 32'(bus.busy), 32'd0);
        chk("t6_async_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("t6_async_done", 32'(bus.frame_done), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
